// File: rtl/play_timer.sv
// play_timer: elapsed-play stopwatch feeding SevenSegment as packed BCD MM:SS.
// Counts whole seconds while the game FSM sits in a playing state, freezes on
// leaving play (keeping the partial second), and clears on return to the menu.
// Optional best-winning-time record is enabled by defining PLAY_TIMER_BEST_EN.
module play_timer #(
    parameter int TICK_DIV   = 100000000,
    parameter int MENU_STATE = 0,
    parameter int RUN_LO     = 3,
    parameter int RUN_HI     = 4,
    parameter int WIN_STATE  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        show_best,
    output logic [15:0] nums,
    output logic        running,
    output logic        sec_tick,
    output logic        sat,
    output logic [15:0] best
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0] DIGITS_MAX = 16'h9959;

    typedef enum logic [1:0] {
        MODE_CLEAR,
        MODE_RUN,
        MODE_HOLD
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      digits_q, digits_d;
    logic             running_q, running_d;
    logic             sec_tick_q, sec_tick_d;
    logic             sat_q, sat_d;
    logic [3:0]       prev_state_q;
    logic [15:0]      digits_inc;
    logic             clr;
    logic             run;

    assign clr = (state == 4'(MENU_STATE));
    assign run = (state >= 4'(RUN_LO)) && (state <= 4'(RUN_HI));

    // BCD +1 across MM:SS; seconds tens roll over at 5, minutes tens never wrap
    always_comb begin
        digits_inc = digits_q;
        if (digits_q[3:0] == 4'd9) begin
            digits_inc[3:0] = 4'd0;
            if (digits_q[7:4] == 4'd5) begin
                digits_inc[7:4] = 4'd0;
                if (digits_q[11:8] == 4'd9) begin
                    digits_inc[11:8]  = 4'd0;
                    digits_inc[15:12] = digits_q[15:12] + 4'd1;
                end else begin
                    digits_inc[11:8] = digits_q[11:8] + 4'd1;
                end
            end else begin
                digits_inc[7:4] = digits_q[7:4] + 4'd1;
            end
        end else begin
            digits_inc[3:0] = digits_q[3:0] + 4'd1;
        end
    end

    // Next-state for mode, prescaler, digits and status flags; menu beats play
    always_comb begin
        mode_d     = mode_q;
        pre_d      = pre_q;
        digits_d   = digits_q;
        running_d  = 1'b0;
        sec_tick_d = 1'b0;
        sat_d      = sat_q;
        if (clr) begin
            mode_d   = MODE_CLEAR;
            pre_d    = '0;
            digits_d = '0;
            sat_d    = 1'b0;
        end else if (run) begin
            mode_d    = MODE_RUN;
            running_d = 1'b1;
            if (pre_q == PRE_LAST) begin
                pre_d      = '0;
                sec_tick_d = 1'b1;
                if (digits_q == DIGITS_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    digits_d = digits_inc;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end else if (mode_q == MODE_RUN) begin
            mode_d = MODE_HOLD;
        end
    end

`ifdef PLAY_TIMER_BEST_EN
    logic [15:0] best_q, best_d;

    // On entry to the win state, keep the lower of the record and the live time
    always_comb begin
        best_d = best_q;
        if ((prev_state_q != 4'(WIN_STATE)) && (state == 4'(WIN_STATE)) &&
            (digits_q < best_q)) begin
            best_d = digits_q;
        end
    end

    // Record register survives menu clears and only resets with rst
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= DIGITS_MAX;
        end else begin
            best_q <= best_d;
        end
    end

    assign best = best_q;
    assign nums = (show_best && !running_q) ? best_q : digits_q;
`else
    logic unused_best_inputs;

    assign unused_best_inputs = show_best ^ (prev_state_q == 4'(WIN_STATE));
    assign best = DIGITS_MAX;
    assign nums = digits_q;
`endif

    // Mode FSM and all registered outputs share one synchronous-reset block
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_CLEAR;
            pre_q        <= '0;
            digits_q     <= '0;
            running_q    <= 1'b0;
            sec_tick_q   <= 1'b0;
            sat_q        <= 1'b0;
            prev_state_q <= 4'd0;
        end else begin
            mode_q       <= mode_d;
            pre_q        <= pre_d;
            digits_q     <= digits_d;
            running_q    <= running_d;
            sec_tick_q   <= sec_tick_d;
            sat_q        <= sat_d;
            prev_state_q <= state;
        end
    end

    assign running  = running_q;
    assign sec_tick = sec_tick_q;
    assign sat      = sat_q;

endmodule
